// File: rtl/pc_gen_pkg.sv
// Shared types for the PC generator: XLEN, FSM states, next-PC source select
// and the jump-target alignment helper.
package pc_gen_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALT
  } pc_state_t;

  typedef enum logic [2:0] {
    SRC_TRAP,
    SRC_REDIRECT,
    SRC_RAS,
    SRC_INC,
    SRC_HOLD
  } pc_src_t;

  function automatic logic [XLEN-1:0] align_target(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:1], 1'b0};
  endfunction

endpackage

// File: rtl/pc_gen_if.sv
// Fetch-side bundle of the PC generator; master is pc_gen, slave is the
// fetch/decode/execute consumer.
interface pc_gen_if;
  import pc_gen_pkg::*;

  logic            fetch_ready;
  logic            compressed;
  logic            trap_en;
  logic [XLEN-1:0] trap_addr;
  logic            redirect_en;
  logic [XLEN-1:0] redirect_addr;
  logic            call;
  logic            ret;
  logic            halt_req;
  logic            fetch_valid;
  logic [XLEN-1:0] curr_pc;
  logic [XLEN-1:0] inc_pc;
  logic [XLEN-1:0] next_pc;
  logic            misalign_err;

  modport master (
    input  fetch_ready, compressed, trap_en, trap_addr, redirect_en,
           redirect_addr, call, ret, halt_req,
    output fetch_valid, curr_pc, inc_pc, next_pc, misalign_err
  );

  modport slave (
    output fetch_ready, compressed, trap_en, trap_addr, redirect_en,
           redirect_addr, call, ret, halt_req,
    input  fetch_valid, curr_pc, inc_pc, next_pc, misalign_err
  );
endinterface

// File: rtl/pc_gen_ras.sv
// Return-address stack (module ras): circular buffer with push, pop,
// replace (push+pop), flush; full pushes overwrite the oldest entry.
module ras #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] top,
  output logic             empty
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    ptr_inc;
  logic [PW-1:0]    ptr_dec;
  logic [CW-1:0]    count;

  always_comb begin
    ptr_inc = ptr + 1'b1;
    ptr_dec = ptr - 1'b1;
    top     = mem[ptr];
    empty   = (count == '0);
  end

  // Push+pop on an empty stack has nothing to replace, so it behaves as a push.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr   <= '0;
      count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      count <= '0;
    end else if (push && pop && !empty) begin
      mem[ptr] <= data;
    end else if (push) begin
      ptr          <= ptr_inc;
      mem[ptr_inc] <= data;
      if (count != CW'(DEPTH)) count <= count + 1'b1;
    end else if (pop && !empty) begin
      ptr   <= ptr_dec;
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator: BOOT/RUN/HALT sequencing, trap/redirect steering
// and optional return-address stack (enabled by macro PC_GEN_RAS_EN).
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter int unsigned     RAS_DEPTH = 4
) (
  input  logic     clk,
  input  logic     reset_n,
  pc_gen_if.master bus
);
  pc_state_t       state_q, state_d;
  pc_src_t         src;
  logic [XLEN-1:0] pc_q, pc_d, inc_pc, ras_top;
  logic            misalign_q, misalign_d;
  logic            accept, steer, ras_hit;

  assign bus.fetch_valid  = (state_q == RUN);
  assign bus.curr_pc      = pc_q;
  assign bus.inc_pc       = inc_pc;
  assign bus.next_pc      = pc_d;
  assign bus.misalign_err = misalign_q;

  assign accept = bus.fetch_valid & bus.fetch_ready;
  assign steer  = bus.trap_en | bus.redirect_en;
  assign inc_pc = pc_q + (bus.compressed ? XLEN'(2) : XLEN'(4));

`ifdef PC_GEN_RAS_EN
  logic ras_empty;

  ras #(.DEPTH(RAS_DEPTH), .WIDTH(XLEN)) u_ras (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (accept & bus.call & ~steer),
    .pop     (accept & bus.ret & ~steer),
    .flush   (bus.trap_en),
    .data    (inc_pc),
    .top     (ras_top),
    .empty   (ras_empty)
  );

  assign ras_hit = accept & bus.ret & ~ras_empty;
`else
  localparam int unsigned UNUSED_RAS_DEPTH = RAS_DEPTH;
  logic unused_hints;

  assign unused_hints = bus.call | bus.ret;
  assign ras_top      = inc_pc;
  assign ras_hit      = 1'b0;
`endif

  always_comb begin
    src        = SRC_HOLD;
    pc_d       = pc_q;
    misalign_d = 1'b0;
    if (bus.trap_en)       src = SRC_TRAP;
    else if (bus.redirect_en) src = SRC_REDIRECT;
    else if (ras_hit)      src = SRC_RAS;
    else if (accept)       src = SRC_INC;
    case (src)
      SRC_TRAP: begin
        pc_d       = align_target(bus.trap_addr);
        misalign_d = bus.trap_addr[0];
      end
      SRC_REDIRECT: begin
        pc_d       = align_target(bus.redirect_addr);
        misalign_d = bus.redirect_addr[0];
      end
      SRC_RAS:  pc_d = ras_top;
      SRC_INC:  pc_d = inc_pc;
      default:  pc_d = pc_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     if (accept && bus.halt_req) state_d = HALT;
      HALT:    if (steer) state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= BOOT;
      pc_q       <= RESET_VEC;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
    end
  end

endmodule
